// File: rtl/pipe_fetch_pkg.sv
// Shared definitions for the fetch stage and the execute pipe: instruction
// layout, func encodings and the fetch state encoding.
package pipe_fetch_pkg;

    localparam int INSTR_W  = 24;
    localparam int FUNC_MSB = 23;
    localparam int FUNC_LSB = 20;
    localparam int RS1_MSB  = 19;
    localparam int RS1_LSB  = 16;
    localparam int RS2_MSB  = 15;
    localparam int RS2_LSB  = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    typedef enum logic [3:0] {
        FUNC_ADD  = 4'd0,
        FUNC_SUB  = 4'd1,
        FUNC_MUL  = 4'd2,
        FUNC_HALT = 4'd15
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] func;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [7:0] addr;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.func = w[FUNC_MSB:FUNC_LSB];
        d.rs1  = w[RS1_MSB:RS1_LSB];
        d.rs2  = w[RS2_MSB:RS2_LSB];
        d.rd   = w[RD_MSB:RD_LSB];
        d.addr = w[ADDR_MSB:ADDR_LSB];
        return d;
    endfunction

    function automatic logic [INSTR_W-1:0] encode(input logic [3:0] f, input logic [3:0] s1,
                                                  input logic [3:0] s2, input logic [3:0] d,
                                                  input logic [7:0] a);
        return {f, s1, s2, d, a};
    endfunction

endpackage

// File: rtl/pipe_fetch_imem.sv
// Instruction memory: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives rst_n.
module pipe_imem
    import pipe_fetch_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_fetch.sv
// Fetch/decode stage: walks instruction memory from start_pc, issuing one
// decoded instruction per unstalled cycle until a HALT word is read.
module pipe_fetch
    import pipe_fetch_pkg::*;
#(
    parameter int         IMEM_DEPTH = 256,
    parameter int         PC_W       = 8,
    parameter logic [3:0] HALT_FUNC  = 4'hF
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               stall,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [3:0]         func,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [3:0]         rd,
    output logic [7:0]         addr,
    output logic               valid,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        issue_cnt
);

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    instr_t             fields_q;
    logic               valid_q;
    logic [15:0]        cnt_q;
    logic [15:0]        cnt_d;

    logic [INSTR_W-1:0] imem_rdata;
    instr_t             fetched;
    logic               imem_we;
    logic               fetch_en;
    logic               is_halt;

    // Writes while running are dropped so the program cannot change under fetch.
    assign imem_we  = prog_we && (state_q != ST_RUN);
    assign fetched  = decode(imem_rdata);
    assign fetch_en = (state_q == ST_RUN) && !stall;
    assign is_halt  = (fetched.func == HALT_FUNC);
    assign pc_d     = pc_q + 1'b1;
    assign cnt_d    = cnt_q + 16'd1;

    pipe_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (PC_W)
    ) u_imem (
        .clk_i   (clk1),
        .we_i    (imem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (imem_rdata)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            fields_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        pc_q    <= start_pc;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fetch_en) begin
                        if (is_halt) begin
                            // pc stays on the HALT word; fields keep the last issue.
                            valid_q <= 1'b0;
                            state_q <= ST_HALTED;
                        end else begin
                            fields_q <= fetched;
                            valid_q  <= 1'b1;
                            pc_q     <= pc_d;
                            cnt_q    <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign func      = fields_q.func;
    assign rs1       = fields_q.rs1;
    assign rs2       = fields_q.rs2;
    assign rd        = fields_q.rd;
    assign addr      = fields_q.addr;
    assign valid     = valid_q;
    assign busy      = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALTED);
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: the reference model expands each program into the
// ordered list of instructions it must issue; a monitor checks every issue.
module tb_pipe_fetch;
    import pipe_fetch_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        stall = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [23:0] prog_data = '0;
    logic [3:0]  func, rs1, rs2, rd;
    logic [7:0]  addr;
    logic        valid, busy, halted;
    logic [15:0] issue_cnt;

    pipe_fetch dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .start_pc(start_pc), .stall(stall),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .func(func), .rs1(rs1), .rs2(rs2), .rd(rd), .addr(addr),
        .valid(valid), .busy(busy), .halted(halted), .issue_cnt(issue_cnt)
    );

    always #5 clk1 = ~clk1;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mem_model [256];
    logic [15:0] model_total = '0;
    logic [7:0]  exp_halt_pc = '0;
    logic [15:0] last_cnt = '0;
    logic [15:0] seen_cnt = '0;

    localparam logic [23:0] W_ADD  = {4'h0, 4'd3,  4'd5, 4'd10, 8'd125};
    localparam logic [23:0] W_MUL  = {4'h2, 4'd3,  4'd8, 4'd12, 8'd126};
    localparam logic [23:0] W_SUB  = {4'h1, 4'd10, 4'd5, 4'd14, 8'd128};
    localparam logic [23:0] W_HALT = {4'hF, 20'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Monitor: every change of issue_cnt marks one issued instruction.
    always @(negedge clk1) begin
        if (!rst_n) begin
            last_cnt = '0;
            seen_cnt = '0;
        end else if (issue_cnt !== last_cnt) begin
            last_cnt = issue_cnt;
            seen_cnt = seen_cnt + 16'd1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got word 0x%0h expected no issue",
                         {func, rs1, rs2, rd, addr});
            end else begin
                check("issue_word", {func, rs1, rs2, rd, addr}, exp_q.pop_front());
                check("issue_valid", valid, 1);
                check("issue_cnt_step", issue_cnt, seen_cnt);
            end
        end
    end

    // Model: execution order from spc until the first HALT word.
    task automatic build_trace(input logic [7:0] spc);
        logic [7:0]  pc;
        logic [23:0] w;
        pc = spc;
        for (int i = 0; i < 256; i++) begin
            w = mem_model[pc];
            if (w[23:20] == 4'hF) begin
                exp_halt_pc = pc;
                break;
            end
            exp_q.push_back(w);
            model_total = model_total + 16'd1;
            pc = pc + 8'd1;
        end
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        #1;
        check("rst_fields", {func, rs1, rs2, rd, addr}, 0);
        check("rst_flags", {valid, busy, halted}, 0);
        check("rst_cnt", issue_cnt, 0);
        exp_q.delete();
        model_total = '0;
        repeat (cyc) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic prog(input logic [7:0] a, input logic [23:0] d);
        logic accepted;
        accepted  = !busy;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
        if (accepted) mem_model[a] = d;
    endtask

    task automatic do_start(input logic [7:0] spc);
        start    = 1'b1;
        start_pc = spc;
        if (!busy) build_trace(spc);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input int stall_pct, input bit noise);
        logic [31:0] r;
        int          n;
        n = 0;
        while (!halted && n < budget) begin
            stall = ($urandom_range(0, 99) < stall_pct);
            if (noise && busy) begin
                r         = $urandom();
                prog_we   = r[0];
                prog_addr = r[15:8];
                prog_data = {r[31:16], r[7:0]};
                start     = r[1] & r[2];
                start_pc  = r[23:16];
            end
            tick();
            n++;
        end
        stall   = 1'b0;
        prog_we = 1'b0;
        start   = 1'b0;
        check("halt_reached", halted, 1);
        check("halt_valid_low", valid, 0);
        check("trace_drained", exp_q.size(), 0);
        check("halt_issue_cnt", issue_cnt, model_total);
        check("halt_pc", dut.pc_q, exp_halt_pc);
        exp_q.delete();
    endtask

    task automatic load_base();
        prog(8'd0, W_ADD);
        prog(8'd1, W_MUL);
        prog(8'd2, W_SUB);
        prog(8'd3, W_HALT);
    endtask

    initial begin
        logic [7:0]  spc;
        logic [31:0] r;
        int          len;

        #2;
        check("init_fields", {func, rs1, rs2, rd, addr}, 0);
        check("init_flags", {valid, busy, halted, issue_cnt}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Basic program with exact per-edge latency.
        load_base();
        start = 1'b1;
        start_pc = 8'd0;
        build_trace(8'd0);
        tick();
        start = 1'b0;
        check("lat_edge1", {valid, busy, halted}, 3'b010);
        tick();
        check("edge2_add", {valid, func, rs1, rs2, rd, addr}, {1'b1, W_ADD});
        tick();
        check("edge3_mul", {valid, func, rs1, rs2, rd, addr}, {1'b1, W_MUL});
        tick();
        check("edge4_sub", {valid, func, rs1, rs2, rd, addr}, {1'b1, W_SUB});
        tick();
        check("edge5_halt", {valid, busy, halted}, 3'b001);
        check("edge5_cnt", issue_cnt, 3);
        check("edge5_fields_kept", {func, rs1, rs2, rd, addr}, W_SUB);
        tick();
        check("halt_valid_stays_low", {valid, halted}, 2'b01);
        exp_q.delete();

        // Stall after first issue; memory kept across reset.
        do_reset(2);
        do_start(8'd0);
        tick();
        check("stall_first_add", {valid, func, rs1, rs2, rd, addr}, {1'b1, W_ADD});
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {valid, func, rs1, rs2, rd, addr}, {1'b1, W_ADD});
            check("stall_hold_cnt", issue_cnt, 1);
        end
        stall = 1'b0;
        tick();
        check("stall_release_mul", {valid, func, rs1, rs2, rd, addr}, {1'b1, W_MUL});
        wait_halt(20, 0, 0);

        // Write during RUN is ignored.
        do_reset(1);
        do_start(8'd0);
        prog(8'd2, 24'h123456);
        wait_halt(20, 0, 0);

        // Reset after the second issue, then restart.
        do_reset(1);
        do_start(8'd0);
        tick();
        tick();
        check("pre_rst_second", issue_cnt, 2);
        do_reset(5);
        repeat (3) tick();
        check("post_rst_idle", {valid, busy, halted}, 0);
        do_start(8'd0);
        wait_halt(20, 0, 0);

        // pc wrap.
        prog(8'd254, {4'h0, 4'd1, 4'd2, 4'd3, 8'd254});
        prog(8'd255, {4'h1, 4'd4, 4'd5, 4'd6, 8'd255});
        prog(8'd0,   {4'h2, 4'd7, 4'd8, 4'd9, 8'd0});
        prog(8'd1,   W_HALT);
        do_reset(1);
        do_start(8'd254);
        wait_halt(20, 0, 0);
        check("wrap_halt_pc", dut.pc_q, 1);

        // Write and start in the same IDLE cycle.
        do_reset(1);
        prog_we   = 1'b1;
        prog_addr = 8'd0;
        prog_data = {4'h1, 4'd15, 4'd14, 4'd13, 8'hA5};
        mem_model[0] = prog_data;
        start    = 1'b1;
        start_pc = 8'd0;
        build_trace(8'd0);
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        wait_halt(20, 0, 0);

        // Random programs with stalls, ignored writes and ignored starts.
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 10);
            r   = $urandom();
            spc = r[7:0];
            for (int i = 0; i < len; i++) begin
                r = $urandom();
                prog(spc + 8'(i), {4'($urandom_range(0, 14)), r[19:0]});
            end
            r = $urandom();
            prog(spc + 8'(len), {4'hF, r[19:0]});
            stall = r[20];
            do_start(spc);
            wait_halt(len * 8 + 20, 30, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
